// File: rtl/dct_two_dimensional.sv
// 8x8 forward DCT: the row pass runs as each row is captured and lands in a ping-pong transpose bank.
// The column pass is emitted as eight parallel beats a fixed latency after the last row of a block.
module dct_two_dimensional #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 12
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     start,
  input  logic [8*DATA_W-1:0]      DCT_data_in,
  output logic signed [DATA_W-1:0] DCT_data_o_z0,
  output logic signed [DATA_W-1:0] DCT_data_o_z1,
  output logic signed [DATA_W-1:0] DCT_data_o_z2,
  output logic signed [DATA_W-1:0] DCT_data_o_z3,
  output logic signed [DATA_W-1:0] DCT_data_o_z4,
  output logic signed [DATA_W-1:0] DCT_data_o_z5,
  output logic signed [DATA_W-1:0] DCT_data_o_z6,
  output logic signed [DATA_W-1:0] DCT_data_o_z7,
  output logic                     data_en
);
  // state  | meaning
  // S_IDLE | no column pass pending
  // S_WAIT | last row of a block written, timer counting down to the first beat
  // S_EMIT | driving beats 1..7 of the current block
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT} state_t;

  localparam int  LAT     = 20;
  localparam real SCALE   = 2.0 ** COEF_W;
  localparam int  SAT_MAX = 2 ** (DATA_W - 1) - 1;
  localparam int  SAT_MIN = -(2 ** (DATA_W - 1));
  localparam int  DC_C    = int'(0.3535533906 * SCALE);
  // 0.5*cos(m*pi/16), m = 0..8
  localparam int  TAB [0:8] = '{int'(0.5 * SCALE), int'(0.4903926402 * SCALE),
                                int'(0.4619397663 * SCALE), int'(0.4157348062 * SCALE),
                                int'(0.3535533906 * SCALE), int'(0.2777851165 * SCALE),
                                int'(0.1913417162 * SCALE), int'(0.0975451610 * SCALE), 0};

  function automatic int coef(input int k, input int n);
    int m;
    if (k == 0) return DC_C;
    m = ((2 * n + 1) * k) % 32;
    if (m > 16) m = 32 - m;
    if (m > 8) return -TAB[16 - m];
    return TAB[m];
  endfunction

  // Round half away from zero while dropping the COEF_W fraction bits.
  function automatic logic signed [31:0] round_q(input logic signed [31:0] s);
    logic signed [31:0] half;
    half = 32'sd1 <<< (COEF_W - 1);
    if (s[31]) half = half - 32'sd1;
    return (s + half) >>> COEF_W;
  endfunction

  state_t                    state, state_nxt;
  logic [2:0]                row_cnt, beat;
  logic                      wr_bank, rd_bank;
  logic [1:0]                bank_full;
  logic [4:0]                timer;
  logic                      row7_wr, emit, finish;
  logic signed [15:0]        cmat    [8][8];
  logic signed [DATA_W-1:0]  x       [8];
  logic signed [15:0]        row_res [8];
  logic signed [DATA_W-1:0]  col_res [8];
  logic signed [DATA_W-1:0]  z       [8];
  logic signed [15:0]        bank    [2][8][8];

  assign row7_wr = start && (row_cnt == 3'd7);

  always_comb begin
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++)
        cmat[k][n] = 16'(coef(k, n));
  end

  always_comb begin
    logic signed [31:0] acc;
    for (int n = 0; n < 8; n++) x[n] = DCT_data_in[(7 - n) * DATA_W +: DATA_W];
    for (int k = 0; k < 8; k++) begin
      acc = '0;
      for (int n = 0; n < 8; n++) acc = acc + 32'(x[n]) * 32'(cmat[k][n]);
      row_res[k] = 16'(round_q(acc));
    end
  end

  // Column pass for vertical frequency 'beat', read from the bank latched at block end.
  always_comb begin
    logic signed [31:0] acc, rq;
    for (int v = 0; v < 8; v++) begin
      acc = '0;
      for (int r = 0; r < 8; r++) acc = acc + 32'(bank[rd_bank][r][v]) * 32'(cmat[beat][r]);
      rq = round_q(acc);
      if (rq > SAT_MAX)      col_res[v] = DATA_W'(SAT_MAX);
      else if (rq < SAT_MIN) col_res[v] = DATA_W'(SAT_MIN);
      else                   col_res[v] = DATA_W'(rq);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (start)
      for (int k = 0; k < 8; k++) bank[wr_bank][row_cnt][k] <= row_res[k];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      S_IDLE: if (row7_wr) state_nxt = S_WAIT;
      S_WAIT: if (timer == '0) begin
        if (bank_full[rd_bank]) begin
          emit      = 1'b1;
          state_nxt = S_EMIT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_EMIT: begin
        emit = 1'b1;
        if (beat == 3'd7) begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      row_cnt   <= '0;
      beat      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= '0;
      timer     <= '0;
      data_en   <= 1'b0;
      for (int i = 0; i < 8; i++) z[i] <= '0;
    end else begin
      data_en <= emit;
      if (start) row_cnt <= row_cnt + 3'd1;
      if (row7_wr) begin
        wr_bank            <= ~wr_bank;
        bank_full[wr_bank] <= 1'b1;
      end
      if (state == S_IDLE && row7_wr) begin
        rd_bank <= wr_bank;
        timer   <= 5'(LAT - 1);
        beat    <= '0;
      end else if (timer != '0) begin
        timer <= timer - 5'd1;
      end
      if (emit) begin
        z    <= col_res;
        beat <= beat + 3'd1;
      end
      if (finish) bank_full[rd_bank] <= 1'b0;
    end
  end

  assign DCT_data_o_z0 = z[0];
  assign DCT_data_o_z1 = z[1];
  assign DCT_data_o_z2 = z[2];
  assign DCT_data_o_z3 = z[3];
  assign DCT_data_o_z4 = z[4];
  assign DCT_data_o_z5 = z[5];
  assign DCT_data_o_z6 = z[6];
  assign DCT_data_o_z7 = z[7];

endmodule

// File: tb/tb_dct_two_dimensional.sv
// Directed bench for dct_two_dimensional: hand-computed key coefficients plus a floating-point
// reference for every coefficient, output latency, burst length and ping-pong independence.
module tb_dct_two_dimensional;
  logic               sys_clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic               start = 1'b0;
  logic [95:0]        DCT_data_in = '0;
  logic signed [11:0] z0, z1, z2, z3, z4, z5, z6, z7;
  logic signed [11:0] zv [8];
  logic               data_en;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_beats = 0;
  int beat_z   [0:63][0:7];
  int beat_cyc [0:63];
  int blk   [8][8];
  int exp_f [2][8][8];
  int jpeg  [8][8] = '{'{38,43,44,45,43,39,34,35}, '{42,43,41,43,45,43,36,34},
                       '{47,46,42,43,45,42,36,35}, '{48,50,47,45,41,36,34,38},
                       '{49,50,49,45,40,34,34,41}, '{51,47,42,41,42,39,37,40},
                       '{51,45,37,38,43,42,38,40}, '{50,45,37,38,42,40,37,40}};

  dct_two_dimensional dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .start        (start),
    .DCT_data_in  (DCT_data_in),
    .DCT_data_o_z0(z0),
    .DCT_data_o_z1(z1),
    .DCT_data_o_z2(z2),
    .DCT_data_o_z3(z3),
    .DCT_data_o_z4(z4),
    .DCT_data_o_z5(z5),
    .DCT_data_o_z6(z6),
    .DCT_data_o_z7(z7),
    .data_en      (data_en)
  );

  assign zv[0] = z0;
  assign zv[1] = z1;
  assign zv[2] = z2;
  assign zv[3] = z3;
  assign zv[4] = z4;
  assign zv[5] = z5;
  assign zv[6] = z6;
  assign zv[7] = z7;

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (data_en && n_beats < 64) begin
      for (int i = 0; i < 8; i++) beat_z[n_beats][i] <= int'(zv[i]);
      beat_cyc[n_beats] <= cyc;
      n_beats <= n_beats + 1;
    end
  end

  task automatic chk(input string tag, input int got, input int expv, input int tol = 0);
    n_tests++;
    if (got - expv > tol || expv - got > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, expv, tol);
    end
  endtask

  task automatic set_const(input int v);
    for (int r = 0; r < 8; r++) for (int n = 0; n < 8; n++) blk[r][n] = v;
  endtask

  task automatic set_alt();
    for (int r = 0; r < 8; r++) for (int n = 0; n < 8; n++) blk[r][n] = (n % 2 == 0) ? 100 : -100;
  endtask

  task automatic set_jpeg();
    for (int r = 0; r < 8; r++) for (int n = 0; n < 8; n++) blk[r][n] = jpeg[r][n];
  endtask

  // Ideal real-valued 2D DCT of blk, rounded half away from zero and saturated.
  task automatic compute_exp(input int slot);
    real pi, s, cu, cv;
    int  f;
    pi = 3.14159265358979;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) begin
        cu = (u == 0) ? 0.7071067812 : 1.0;
        cv = (v == 0) ? 0.7071067812 : 1.0;
        s  = 0.0;
        for (int r = 0; r < 8; r++)
          for (int n = 0; n < 8; n++)
            s += real'(blk[r][n]) * $cos((2 * r + 1) * u * pi / 16.0) * $cos((2 * n + 1) * v * pi / 16.0);
        s = s * cu * cv / 4.0;
        f = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
        if (f > 2047)  f = 2047;
        if (f < -2048) f = -2048;
        exp_f[slot][u][v] = f;
      end
  endtask

  task automatic send_rows(input int count, output int t_last);
    t_last = 0;
    for (int r = 0; r < count; r++) begin
      @(negedge sys_clk);
      for (int n = 0; n < 8; n++) DCT_data_in[(7 - n) * 12 +: 12] = 12'(blk[r][n]);
      start = 1'b1;
      if (r == count - 1) begin
        @(posedge sys_clk);
        #1 t_last = cyc;
      end
      @(negedge sys_clk);
      start = 1'b0;
      repeat (6) @(negedge sys_clk);
    end
  endtask

  task automatic wait_beats(input int target);
    int k;
    k = 0;
    while (n_beats < target && k < 300) begin
      @(negedge sys_clk);
      k++;
    end
  endtask

  task automatic check_burst(input int base, input int slot, input string tag);
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 8; i++)
        chk($sformatf("%s_F%0d%0d", tag, j, i), beat_z[base + j][i], exp_f[slot][j][i], 1);
  endtask

  task automatic run_block(input string tag, output int base);
    int t7;
    compute_exp(0);
    base = n_beats;
    send_rows(8, t7);
    wait_beats(base + 8);
    repeat (12) @(negedge sys_clk);
    chk({tag, "_len"}, n_beats - base, 8);
    chk({tag, "_lat"}, beat_cyc[base] - t7, 20);
    chk({tag, "_contig"}, beat_cyc[base + 7] - beat_cyc[base], 7);
    check_burst(base, 0, tag);
  endtask

  initial begin
    int base, ta, tb, t;
    repeat (3) @(negedge sys_clk);
    chk("rst_en", int'(data_en), 0);
    chk("rst_z0", int'(z0), 0);
    chk("rst_z7", int'(z7), 0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    set_const(100);
    run_block("c100", base);
    chk("c100_dc", beat_z[base][0], 800);
    chk("c100_z1", beat_z[base][1], 0);

    set_jpeg();
    run_block("jpeg", base);
    chk("jpeg_dc", beat_z[base][0], 333, 1);

    set_const(-2048);
    run_block("neg", base);
    chk("neg_dc", beat_z[base][0], -2048);
    chk("neg_f01", beat_z[base][1], 0);
    chk("neg_f10", beat_z[base + 1][0], 0);

    set_alt();
    run_block("alt", base);
    chk("alt_z0", beat_z[base][0], 0);
    chk("alt_z1", beat_z[base][1], 144);
    chk("alt_z2", beat_z[base][2], 0);
    chk("alt_z3", beat_z[base][3], 170);
    chk("alt_z5", beat_z[base][5], 255);
    chk("alt_z7", beat_z[base][7], 724);
    chk("alt_b3z7", beat_z[base + 3][7], 0);

    // Back-to-back blocks: JPEG block then alternating rows, continuous 8-cycle spacing.
    set_jpeg();
    compute_exp(0);
    base = n_beats;
    send_rows(8, ta);
    set_alt();
    compute_exp(1);
    send_rows(8, tb);
    wait_beats(base + 16);
    repeat (12) @(negedge sys_clk);
    chk("b2b_len", n_beats - base, 16);
    chk("b2b_lat0", beat_cyc[base] - ta, 20);
    chk("b2b_lat1", beat_cyc[base + 8] - tb, 20);
    chk("b2b_gap", beat_cyc[base + 8] - beat_cyc[base], 64);
    check_burst(base, 0, "b2bA");
    check_burst(base + 8, 1, "b2bB");

    // Reset after five rows: the partial block must vanish and row counting restart.
    set_const(-2048);
    base = n_beats;
    send_rows(5, t);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("mid_rst_en", int'(data_en), 0);
    sys_rst_n = 1'b1;
    repeat (40) @(negedge sys_clk);
    chk("mid_no_burst", n_beats - base, 0);
    set_alt();
    run_block("post_rst", base);
    chk("post_rst_z7", beat_z[base][7], 724);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
